// File: rtl/hub75_fb_feeder_pkg.sv
// hub75_fb_feeder_pkg: shared constants and types for the frame buffer feeder
package hub75_fb_feeder_pkg;
  localparam int STAT_CNT_W = 8;
  typedef logic [STAT_CNT_W-1:0] frame_cnt_t;
endpackage

// File: rtl/hub75_fb_feeder_if.sv
// hub75_fb_feeder_if: pixel stream, line-buffer write, store/swap handshakes and status
interface hub75_fb_feeder_if
  import hub75_fb_feeder_pkg::*;
#(
  parameter int N_BANKS  = 2,
  parameter int N_ROWS   = 32,
  parameter int N_COLS   = 64,
  parameter int BITDEPTH = 24
);
  localparam int LOG_N_BANKS = $clog2(N_BANKS);
  localparam int LOG_N_ROWS  = $clog2(N_ROWS);
  localparam int LOG_N_COLS  = $clog2(N_COLS);
  logic [BITDEPTH-1:0]    in_data;
  logic                   in_sof;
  logic                   in_valid;
  logic                   in_ready;
  logic [LOG_N_BANKS-1:0] fbw_bank_addr;
  logic [LOG_N_ROWS-1:0]  fbw_row_addr;
  logic                   fbw_row_store;
  logic                   fbw_row_rdy;
  logic                   fbw_row_swap;
  logic [BITDEPTH-1:0]    fbw_data;
  logic [LOG_N_COLS-1:0]  fbw_col_addr;
  logic                   fbw_wren;
  logic                   frame_swap;
  logic                   frame_rdy;
  logic                   stat_resync;
  frame_cnt_t             stat_frame_cnt;
  modport master (
    input  in_data, in_sof, in_valid, fbw_row_rdy, frame_rdy,
    output in_ready, fbw_bank_addr, fbw_row_addr, fbw_row_store, fbw_row_swap,
           fbw_data, fbw_col_addr, fbw_wren, frame_swap, stat_resync, stat_frame_cnt
  );
  modport slave (
    output in_data, in_sof, in_valid, fbw_row_rdy, frame_rdy,
    input  in_ready, fbw_bank_addr, fbw_row_addr, fbw_row_store, fbw_row_swap,
           fbw_data, fbw_col_addr, fbw_wren, frame_swap, stat_resync, stat_frame_cnt
  );
endinterface

// File: rtl/hub75_fb_feeder.sv
// hub75_fb_feeder: writes a raster pixel stream into the line buffer, sequencing row stores and frame swaps
module hub75_fb_feeder
  import hub75_fb_feeder_pkg::*;
#(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int BITDEPTH    = 24,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
)(
  input logic             clk,
  input logic             rst,
  hub75_fb_feeder_if.master bus
);
  localparam logic [2:0] S_FILL        = 3'd0;
  localparam logic [2:0] S_ROW_WAIT    = 3'd1;
  localparam logic [2:0] S_FRAME_GUARD = 3'd2;
  localparam logic [2:0] S_FRAME_DRAIN = 3'd3;
  localparam logic [2:0] S_FRAME_SWAP  = 3'd4;
  localparam logic [2:0] S_SWAP_GUARD  = 3'd5;
  localparam logic [2:0] S_SWAP_WAIT   = 3'd6;
  localparam logic [LOG_N_COLS-1:0]  COL_MAX  = LOG_N_COLS'(N_COLS - 1);
  localparam logic [LOG_N_ROWS-1:0]  ROW_MAX  = LOG_N_ROWS'(N_ROWS - 1);
  localparam logic [LOG_N_BANKS-1:0] BANK_MAX = LOG_N_BANKS'(N_BANKS - 1);
  localparam int LINE_W = LOG_N_BANKS + LOG_N_ROWS;
  logic [2:0]             state_q, state_d;
  logic                   run_q;
  logic [LOG_N_COLS-1:0]  col_q, col_d, eff_col;
  logic [LOG_N_ROWS-1:0]  row_q, row_d, eff_row;
  logic [LOG_N_BANKS-1:0] bank_q, bank_d, eff_bank;
  logic                   accept, last_col, last_line, nonzero;
  logic                   wren_q, store_q, resync_q;
  logic [BITDEPTH-1:0]    data_q;
  logic [LOG_N_COLS-1:0]  col_addr_q;
  logic [LOG_N_ROWS-1:0]  row_addr_q;
  logic [LOG_N_BANKS-1:0] bank_addr_q;
  frame_cnt_t             frame_cnt_q;

  // run_q keeps in_ready low until the first edge after reset release
  assign bus.in_ready       = run_q && state_q == S_FILL;
  assign accept             = bus.in_valid && bus.in_ready;
  assign nonzero            = |{col_q, row_q, bank_q};
  assign eff_col            = bus.in_sof ? '0 : col_q;
  assign eff_row            = bus.in_sof ? '0 : row_q;
  assign eff_bank           = bus.in_sof ? '0 : bank_q;
  assign last_col           = eff_col == COL_MAX;
  assign last_line          = row_q == ROW_MAX && bank_q == BANK_MAX;
  assign bus.fbw_wren       = wren_q;
  assign bus.fbw_data       = data_q;
  assign bus.fbw_col_addr   = col_addr_q;
  assign bus.fbw_bank_addr  = bank_addr_q;
  assign bus.fbw_row_addr   = row_addr_q;
  assign bus.fbw_row_store  = store_q;
  assign bus.fbw_row_swap   = store_q;
  assign bus.frame_swap     = state_q == S_FRAME_SWAP;
  assign bus.stat_resync    = resync_q;
  assign bus.stat_frame_cnt = frame_cnt_q;

  // sequencing FSM and raster position counters; SOF forces the position back to 0/0/0
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    bank_d  = bank_q;
    case (state_q)
      S_FILL: if (accept) begin
        col_d   = eff_col + 1'b1;
        row_d   = eff_row;
        bank_d  = eff_bank;
        state_d = last_col ? S_ROW_WAIT : S_FILL;
      end
      S_ROW_WAIT: if (bus.fbw_row_rdy) begin
        state_d = last_line ? S_FRAME_GUARD : S_FILL;
        if (!last_line) {bank_d, row_d} = {bank_q, row_q} + LINE_W'(1);
      end
      S_FRAME_GUARD: state_d = S_FRAME_DRAIN;
      S_FRAME_DRAIN: state_d = bus.fbw_row_rdy ? S_FRAME_SWAP : S_FRAME_DRAIN;
      S_FRAME_SWAP: begin
        row_d   = '0;
        bank_d  = '0;
        state_d = S_SWAP_GUARD;
      end
      S_SWAP_GUARD: state_d = S_SWAP_WAIT;
      S_SWAP_WAIT: state_d = bus.frame_rdy ? S_FILL : S_SWAP_WAIT;
      default: state_d = S_FILL;
    endcase
  end

  // state, registered write port, one-cycle pulses and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      run_q       <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      bank_q      <= '0;
      wren_q      <= 1'b0;
      store_q     <= 1'b0;
      resync_q    <= 1'b0;
      data_q      <= '0;
      col_addr_q  <= '0;
      row_addr_q  <= '0;
      bank_addr_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      col_q    <= col_d;
      row_q    <= row_d;
      bank_q   <= bank_d;
      wren_q   <= accept;
      store_q  <= state_q == S_ROW_WAIT && bus.fbw_row_rdy;
      resync_q <= accept && bus.in_sof && nonzero;
      if (accept) begin
        data_q     <= bus.in_data;
        col_addr_q <= eff_col;
      end
      if (accept && last_col) begin
        bank_addr_q <= eff_bank;
        row_addr_q  <= eff_row;
      end
      if (state_q == S_FRAME_SWAP) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_hub75_fb_feeder.sv
// tb_hub75_fb_feeder: scoreboard bench for the frame buffer feeder
module tb_hub75_fb_feeder;
  localparam int NB = 2;
  localparam int NR = 4;
  localparam int NC = 8;
  localparam int BD = 24;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_store_cyc = -1;
  int store_cnt = 0;
  int resync_cnt = 0;
  int pend = -1;
  int m_col = 0, m_row = 0, m_bank = 0, m_frames = 0;
  logic [31:0] wq[$];
  logic [7:0]  sq[$];
  int          fq[$];
  int          rsq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hub75_fb_feeder_if #(.N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .BITDEPTH(BD)) bus ();
  hub75_fb_feeder #(.N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .BITDEPTH(BD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // positional model of where each accepted pixel must land
  task automatic model_accept(input logic [BD-1:0] d, input logic s);
    if (s) begin
      if (m_col != 0 || m_row != 0 || m_bank != 0) rsq.push_back(1);
      m_col = 0; m_row = 0; m_bank = 0;
    end
    wq.push_back({d, 8'(m_col)});
    m_col++;
    if (m_col == NC) begin
      m_col = 0;
      sq.push_back({4'(m_bank), 4'(m_row)});
      m_row++;
      if (m_row == NR) begin
        m_row = 0;
        m_bank++;
        if (m_bank == NB) begin
          m_bank = 0;
          m_frames++;
          fq.push_back(m_frames);
        end
      end
    end
  endtask

  task automatic send(input logic [BD-1:0] d, input logic s);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = s;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    model_accept(d, s);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((wq.size() || sq.size() || fq.size() || rsq.size() || pend >= 0) && n < 100) begin
      n++;
      wait_cyc(1);
    end
    chk("queues_drained", wq.size() + sq.size() + fq.size() + rsq.size(), 0);
  endtask

  // monitor: every DUT event is checked against the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (pend >= 0) begin
        chk("frame_cnt", bus.stat_frame_cnt, pend);
        pend = -1;
      end
      if (bus.fbw_wren) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else chk("write", {bus.fbw_data, 8'(bus.fbw_col_addr)}, wq.pop_front());
      end
      if (bus.fbw_row_store || bus.fbw_row_swap) chk("swap_eq_store", bus.fbw_row_swap, bus.fbw_row_store);
      if (bus.fbw_row_store) begin
        store_cnt++;
        last_store_cyc = cyc;
        if (sq.size() == 0) chk("unexpected_store", 1, 0);
        else chk("store_addr", {4'(bus.fbw_bank_addr), 4'(bus.fbw_row_addr)}, sq.pop_front());
      end
      if (bus.frame_swap) begin
        if (fq.size() == 0) chk("unexpected_frame_swap", 1, 0);
        else pend = fq.pop_front();
      end
      if (bus.stat_resync) begin
        resync_cnt++;
        if (rsq.size() == 0) chk("unexpected_resync", 1, 0);
        else void'(rsq.pop_front());
      end
    end
  end

  initial begin
    int n;
    bus.in_valid    = 1'b0;
    bus.in_sof      = 1'b0;
    bus.in_data     = '0;
    bus.fbw_row_rdy = 1'b1;
    bus.frame_rdy   = 1'b1;
    wait_cyc(3);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wren", bus.fbw_wren, 0);
    chk("rst_store", bus.fbw_row_store, 0);
    chk("rst_frame_swap", bus.frame_swap, 0);
    chk("rst_frame_cnt", bus.stat_frame_cnt, 0);
    chk("rst_data", bus.fbw_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_release", bus.in_ready, 1);
    // single row with SOF at origin
    for (int i = 0; i < NC; i++) send(BD'(i + 1), i == 0);
    @(negedge clk);
    chk("ready_row_wait", bus.in_ready, 0);
    wait_cyc(3);
    chk("store_latency", last_store_cyc, acc_cyc + 1);
    chk("one_store", store_cnt, 1);
    chk("no_resync_at_origin", resync_cnt, 0);
    // rest of the first frame
    for (int i = NC; i < NB * NR * NC; i++) send(BD'(i + 1), 1'b0);
    wait_done();
    chk("frame_cnt_1", bus.stat_frame_cnt, 1);
    chk("stores_frame1", store_cnt, NB * NR);
    // row store held off by fbw_row_rdy
    bus.fbw_row_rdy = 1'b0;
    for (int i = 0; i < NC; i++) send(BD'(24'h100 + i), 1'b0);
    n = store_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_ready", bus.in_ready, 0);
    end
    chk("stall_no_store", store_cnt, n);
    @(posedge clk);
    #1;
    bus.fbw_row_rdy = 1'b1;
    wait_cyc(3);
    chk("store_after_rdy", store_cnt, n + 1);
    // finish frame with frame_rdy held low
    bus.frame_rdy = 1'b0;
    for (int i = NC; i < NB * NR * NC; i++) send(BD'(24'h100 + i), 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("swap_wait_ready", bus.in_ready, 0);
    end
    wait_done();
    chk("frame_cnt_2", bus.stat_frame_cnt, 2);
    @(posedge clk);
    #1;
    bus.frame_rdy = 1'b1;
    // new frame; SOF on the 13th pixel discards the partial row 1
    n = store_cnt;
    for (int i = 0; i < 12; i++) send(BD'(24'h200 + i), 1'b0);
    send(24'h2AA, 1'b1);
    for (int i = 0; i < NC - 1; i++) send(BD'(24'h300 + i), 1'b0);
    wait_done();
    chk("resync_pulses", resync_cnt, 1);
    chk("stores_resync", store_cnt, n + 2);
    // reset while a row store is pending
    bus.fbw_row_rdy = 1'b0;
    for (int i = 0; i < NC; i++) send(BD'(24'h400 + i), 1'b0);
    wait_cyc(2);
    void'(sq.pop_back());
    m_col = 0; m_row = 0; m_bank = 0; m_frames = 0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_wren", bus.fbw_wren, 0);
    chk("mid_rst_store", bus.fbw_row_store, 0);
    chk("mid_rst_addr", {bus.fbw_bank_addr, bus.fbw_row_addr, bus.fbw_col_addr}, 0);
    chk("mid_rst_data", bus.fbw_data, 0);
    chk("mid_rst_frame_cnt", bus.stat_frame_cnt, 0);
    wait_cyc(3);
    bus.fbw_row_rdy = 1'b1;
    rst = 1'b0;
    n = store_cnt;
    wait_cyc(10);
    chk("abandoned_store", store_cnt, n);
    for (int i = 0; i < NC; i++) send(BD'(24'h500 + i), 1'b0);
    wait_done();
    chk("restart_store", store_cnt, n + 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
